// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper: FSM state encoding,
// default sizing and the vector-count helper.
package sweeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int DEFAULT_N_IN          = 3;
  localparam int DEFAULT_SETTLE_CYCLES = 2;

  function automatic int num_vectors(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/sweep_settle_timer.sv
// Settle timer: cleared while load is high, then counts up and saturates;
// expire flags the last settle cycle of the current vector.
module sweep_settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  output logic o_expire
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(SETTLE_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          w_at_last;

  assign w_at_last = (r_cnt == LAST_CNT);
  assign o_expire  = w_at_last;

  always_ff @(posedge clk) begin
    if (rst || i_load) begin
      r_cnt <= '0;
    end else if (!w_at_last) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every input vector of a small combinational datapath in ascending
// order, captures its output per vector and compares against an expected table.
module truth_table_sweeper
  import sweeper_pkg::*;
#(
  parameter int N_IN          = DEFAULT_N_IN,
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
  localparam int V            = num_vectors(N_IN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [V-1:0]    expected,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic [V-1:0]    table_out,
  output logic            pass,
  output logic [N_IN:0]   mismatch_count,
  output logic [N_IN-1:0] first_mismatch
);

  localparam logic [N_IN-1:0] LAST_IDX = '1;

  state_t          r_state;
  logic [N_IN-1:0] r_idx;
  logic [V-1:0]    r_expected;
  logic [V-1:0]    r_table;
  logic [N_IN:0]   r_count;
  logic [N_IN-1:0] r_first;
  logic            r_pass;
  logic            r_busy;
  logic            r_done;

  logic w_timer_load;
  logic w_expire;
  logic w_miss;
  logic w_last;

  // The timer only runs in SETTLE, so it starts from zero on every vector.
  assign w_timer_load = (r_state != ST_SETTLE);
  assign w_miss       = dut_out ^ r_expected[r_idx];
  assign w_last       = (r_idx == LAST_IDX);

  sweep_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_timer_load),
    .o_expire(w_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_expected <= '0;
      r_table    <= '0;
      r_count    <= '0;
      r_first    <= '0;
      r_pass     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_expected <= expected;
            r_idx      <= '0;
            r_table    <= '0;
            r_count    <= '0;
            r_first    <= '0;
            r_pass     <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
          end else if (w_expire) begin
            r_state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          // Abort wins over the capture, leaving partial results untouched.
          if (abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
          end else begin
            r_table[r_idx] <= dut_out;
            if (w_miss) begin
              r_count <= r_count + 1'b1;
              if (r_count == '0) begin
                r_first <= r_idx;
              end
            end
            if (w_last) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              // Count register has not absorbed this sample yet.
              r_pass  <= (r_count == '0) && !w_miss;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= ST_SETTLE;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign dut_in         = r_idx;
  assign busy           = r_busy;
  assign done           = r_done;
  assign table_out      = r_table;
  assign pass           = r_pass;
  assign mismatch_count = r_count;
  assign first_mismatch = r_first;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: table of sweeps against a faultable
// datapath model, plus abort, reset, back-to-back and short-settle sequences.
module tb_truth_table_sweeper;

  localparam int N = 3;
  localparam int V = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, abort, start1, abort1;
  logic [V-1:0] expected;
  logic [N-1:0] dut_in, dut_in1;
  logic         dut_out, dut_out1;
  logic         busy, done, pass, busy1, done1, pass1;
  logic [V-1:0] table_out, table_out1;
  logic [N:0]   mismatch_count, mismatch_count1;
  logic [N-1:0] first_mismatch, first_mismatch1;

  // Datapath model: expected function, with per-vector stuck-at-0 / stuck-at-1 faults
  logic [V-1:0] m_exp, m_f0, m_f1;
  assign dut_out  = (m_exp[dut_in] & ~m_f0[dut_in]) | m_f1[dut_in];
  assign dut_out1 = m_exp[dut_in1];

  truth_table_sweeper #(.N_IN(N), .SETTLE_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .expected(expected),
    .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done),
    .table_out(table_out), .pass(pass), .mismatch_count(mismatch_count),
    .first_mismatch(first_mismatch)
  );

  truth_table_sweeper #(.N_IN(N), .SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .expected(expected),
    .dut_in(dut_in1), .dut_out(dut_out1), .busy(busy1), .done(done1),
    .table_out(table_out1), .pass(pass1), .mismatch_count(mismatch_count1),
    .first_mismatch(first_mismatch1)
  );

  typedef struct {
    logic [7:0] exp_in;
    logic [7:0] f0;
    logic [7:0] f1;
    logic [7:0] tbl;
    logic       pss;
    logic [3:0] cnt;
    logic [2:0] fst;
  } vec_t;

  vec_t vecs [7];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  // Pulse start, then follow the sweep until done (bounded). Optional start
  // pulses at pulse_at and pulse_at+5 cycles into the sweep must be ignored.
  task automatic run_sweep(input logic [7:0] e, input logic [7:0] f0, input logic [7:0] f1,
                           input int pulse_at, output int lat, output int busy_cyc,
                           output int order_bad);
    m_exp = e; m_f0 = f0; m_f1 = f1; expected = e;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    lat = 0; busy_cyc = 0; order_bad = 0;
    while (!done && lat < 200) begin
      start = (pulse_at >= 0) && (lat == pulse_at || lat == pulse_at + 5);
      if (busy) busy_cyc++;
      if (lat < 24 && int'(dut_in) != lat / 3) order_bad++;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic wait_dut_in(input logic [N-1:0] v);
    int k = 0;
    while (dut_in !== v && k < 100) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic count_done(input int cycles, output int seen);
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (done) seen++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bc, ob, seen, g;

    rst = 1'b1; start = 1'b0; abort = 1'b0; start1 = 1'b0; abort1 = 1'b0;
    expected = '0; m_exp = '0; m_f0 = '0; m_f1 = '0;

    vecs[0] = '{8'hE8, 8'h00, 8'h00, 8'hE8, 1'b1, 4'd0, 3'd0};
    vecs[1] = '{8'hE8, 8'h48, 8'h00, 8'hA0, 1'b0, 4'd2, 3'd3};
    vecs[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 4'd0, 3'd0};
    vecs[3] = '{8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, 4'd8, 3'd0};
    vecs[4] = '{8'h81, 8'h80, 8'h00, 8'h01, 1'b0, 4'd1, 3'd7};
    vecs[5] = '{8'h5A, 8'h02, 8'h00, 8'h58, 1'b0, 4'd1, 3'd1};
    vecs[6] = '{8'h00, 8'h00, 8'h80, 8'h80, 1'b0, 4'd1, 3'd7};

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dut_in", dut_in, 0);
    check("rst_table", table_out, 0);
    check("rst_pass", pass, 0);
    check("rst_count", mismatch_count, 0);
    check("rst_first", first_mismatch, 0);
    check("rst_busy_sc1", busy1, 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_sweep(vecs[i].exp_in, vecs[i].f0, vecs[i].f1, -1, lat, bc, ob);
      $display("vec %0d exp=%h f0=%h f1=%h table=%h pass=%b cnt=%0d first=%0d lat=%0d",
               i, vecs[i].exp_in, vecs[i].f0, vecs[i].f1, table_out, pass,
               mismatch_count, first_mismatch, lat);
      check("latency", lat, 24);
      check("busy_cycles", bc, 24);
      check("vec_order", ob, 0);
      check("table_out", table_out, vecs[i].tbl);
      check("pass", pass, vecs[i].pss);
      check("mismatch_count", mismatch_count, vecs[i].cnt);
      check("first_mismatch", first_mismatch, vecs[i].fst);
      @(negedge clk);
      check("done_one_cycle", done, 0);
    end

    // start pulses while busy must not restart the sweep
    run_sweep(8'hE8, 8'h00, 8'h00, 4, lat, bc, ob);
    $display("busy-start sweep lat=%0d busy=%0d order_bad=%0d", lat, bc, ob);
    check("busy_start_lat", lat, 24);
    check("busy_start_busy", bc, 24);
    check("busy_start_order", ob, 0);
    repeat (2) @(negedge clk);
    check("busy_start_idle", busy, 0);

    // abort while vector 4 is on the datapath
    m_exp = 8'hE8; m_f0 = 8'h00; m_f1 = 8'h00; expected = 8'hE8;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_dut_in(3'd4);
    check("abort_reach", dut_in, 4);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    $display("abort: busy=%b done=%b pass=%b table=%h", busy, done, pass, table_out);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_pass", pass, 0);
    check("abort_table", table_out, 8'h08);
    count_done(40, seen);
    check("abort_no_done", seen, 0);
    run_sweep(8'hE8, 8'h00, 8'h00, -1, lat, bc, ob);
    $display("post-abort sweep lat=%0d table=%h pass=%b", lat, table_out, pass);
    check("post_abort_lat", lat, 24);
    check("post_abort_pass", pass, 1);
    check("post_abort_table", table_out, 8'hE8);

    // reset in the middle of a faulty sweep
    m_exp = 8'hE8; m_f0 = 8'h48; expected = 8'hE8;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_dut_in(3'd5);
    check("rst_mid_reach", dut_in, 5);
    check("rst_mid_pre_count", mismatch_count, 1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    $display("mid-sweep reset: dut_in=%0d busy=%b cnt=%0d first=%0d", dut_in, busy,
             mismatch_count, first_mismatch);
    check("rst_mid_dut_in", dut_in, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_count", mismatch_count, 0);
    check("rst_mid_first", first_mismatch, 0);
    check("rst_mid_table", table_out, 0);
    count_done(40, seen);
    check("rst_mid_no_done", seen, 0);

    // start held high: second sweep follows immediately after the first
    m_exp = 8'hE8; m_f0 = 8'h00; expected = 8'hE8;
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    lat = 0;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_first_lat", lat, 24);
    g = 0;
    @(negedge clk);
    while (!done && g < 100) begin
      g++;
      @(negedge clk);
    end
    start = 1'b0;
    $display("back-to-back: first lat=%0d gap=%0d pass=%b", lat, g, pass);
    check("b2b_gap", g, 25);
    check("b2b_pass", pass, 1);
    repeat (3) @(negedge clk);
    check("b2b_stopped", busy, 0);

    // SETTLE_CYCLES=1 instance
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    lat = 0;
    while (!done1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    $display("settle1 sweep lat=%0d table=%h pass=%b", lat, table_out1, pass1);
    check("sc1_latency", lat, 16);
    check("sc1_table", table_out1, 8'hE8);
    check("sc1_pass", pass1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
